addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pipe.sv | 110 +++++++++++
 tb/tb_addsub_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pipe
// Brief    : Two-stage pipelined add/subtract unit with valid/ready handshake
//            and carry/overflow/zero/negative flags.
// Revision : 1.0
// ============================================================================
module addsub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int HALF = WIDTH / 2;

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_advance;
    logic             accept;

    logic [HALF-1:0]  b_lo_eff;
    logic [HALF-1:0]  b_hi_eff;
    logic [HALF:0]    lo_sum;
    logic [HALF:0]    hi_sum;

    logic [HALF-1:0]  s1_lo_sum;
    logic [HALF-1:0]  s1_a_hi;
    logic [HALF-1:0]  s1_b_hi;
    logic             s1_lo_carry;
    logic             s1_op;

    logic [WIDTH-1:0] result_next;
    logic             carry_next;
    logic             overflow_next;

    // Handshake: stage 2 frees when empty or drained; stage 1 frees when
    // empty or moving into stage 2.
    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign accept     = in_valid && in_ready;

    // Subtraction reuses the adder: invert b and inject op as the carry-in.
    assign b_lo_eff = op ? ~b[HALF-1:0]     : b[HALF-1:0];
    assign b_hi_eff = op ? ~b[WIDTH-1:HALF] : b[WIDTH-1:HALF];
    assign lo_sum   = {1'b0, a[HALF-1:0]} + {1'b0, b_lo_eff} + {{HALF{1'b0}}, op};

    assign hi_sum   = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {{HALF{1'b0}}, s1_lo_carry};

    assign result_next   = {hi_sum[HALF-1:0], s1_lo_sum};
    assign carry_next    = hi_sum[HALF] ^ s1_op;
    assign overflow_next = (s1_a_hi[HALF-1] == s1_b_hi[HALF-1]) &&
                           (hi_sum[HALF-1] != s1_a_hi[HALF-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_lo_sum   <= '0;
            s1_lo_carry <= 1'b0;
            s1_a_hi     <= '0;
            s1_b_hi     <= '0;
            s1_op       <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_lo_sum   <= lo_sum[HALF-1:0];
                s1_lo_carry <= lo_sum[HALF];
                s1_a_hi     <= a[WIDTH-1:HALF];
                s1_b_hi     <= b_hi_eff;
                s1_op       <= op;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result   <= result_next;
                carry    <= carry_next;
                overflow <= overflow_next;
                zero     <= (result_next == '0);
                negative <= result_next[WIDTH-1];
            end
        end
    end

    assign out_valid = s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_pipe
// Brief    : Self-checking bench for addsub_pipe (WIDTH=8 and WIDTH=16).
// Revision : 1.0
// ============================================================================
module tb_addsub_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, op, out_ready;
    logic [7:0] a, b;
    logic       in_ready, out_valid;
    logic [7:0] result;
    logic       carry, overflow, zero, negative;

    logic        in_valid16, op16, out_ready16;
    logic [15:0] a16, b16;
    logic        in_ready16, out_valid16;
    logic [15:0] result16;
    logic        carry16, overflow16, zero16, negative16;

    int tests = 0;
    int fails = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow), .zero(zero),
        .negative(negative)
    );

    addsub_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .op(op16), .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .carry(carry16), .overflow(overflow16), .zero(zero16),
        .negative(negative16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic. Packs {result, carry, overflow, zero, negative}.
    function automatic logic [11:0] model8(input logic o, input logic [7:0] x, input logic [7:0] y);
        int ux, uy, sx, sy, ur, sr, res;
        logic c, v;
        ux = int'(x); uy = int'(y);
        sx = (ux >= 128) ? ux - 256 : ux;
        sy = (uy >= 128) ? uy - 256 : uy;
        if (!o) begin
            ur = ux + uy; c = (ur > 255); sr = sx + sy;
        end else begin
            ur = ux - uy; c = (ux < uy); sr = sx - sy;
        end
        res = (ur + 256) % 256;
        v = (sr > 127) || (sr < -128);
        return {res[7:0], c, v, (res == 0), (res >= 128)};
    endfunction

    // Scoreboard: every cycle with out_valid, compare to the oldest outstanding op.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL stale_output: got result %0h with no op outstanding", result);
                end else begin
                    check("stream", {20'd0, result, carry, overflow, zero, negative}, {20'd0, exp_q[0]});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model8(op, a, b));
        end
    end

    task automatic directed(input string name, input logic o, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] er, input logic ec, input logic ev, input logic ez, input logic en);
        out_ready = 1'b1; in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({name, "_lat2"}, {31'd0, out_valid}, 32'd1);
        check({name, "_res"}, {24'd0, result}, {24'd0, er});
        check({name, "_flags"}, {28'd0, carry, overflow, zero, negative}, {28'd0, ec, ev, ez, en});
        @(posedge clk); #1;
    endtask

    task automatic send(input logic o, input logic [7:0] x, input logic [7:0] y);
        int n;
        bit done;
        n = 0; done = 0;
        in_valid = 1'b1; op = o; a = x; b = y;
        while (!done && n < 50) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        in_valid16 = 1'b0; op16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;

        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out", {19'd0, out_valid, result, carry, overflow, zero, negative}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        directed("sub_7_3",     1'b1, 8'd7,   8'd3,   8'd4,   1'b0, 1'b0, 1'b0, 1'b0);
        directed("sub_5_m127",  1'b1, 8'd5,   8'd129, 8'd132, 1'b1, 1'b1, 1'b0, 1'b1);
        directed("sub_m127_5",  1'b1, 8'd129, 8'd5,   8'd124, 1'b0, 1'b1, 1'b0, 1'b0);
        directed("add_127_1",   1'b0, 8'd127, 8'd1,   8'd128, 1'b0, 1'b1, 1'b0, 1'b1);
        directed("add_255_1",   1'b0, 8'd255, 8'd1,   8'd0,   1'b1, 1'b0, 1'b1, 1'b0);

        // Four back-to-back ops with the consumer stalled for four edges.
        out_ready = 1'b1;
        fork
            begin
                send(1'b0, 8'd10,  8'd20);
                send(1'b1, 8'd3,   8'd9);
                send(1'b0, 8'd200, 8'd100);
                send(1'b1, 8'd128, 8'd1);
            end
            begin
                @(posedge clk); @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("stall_drained", exp_q.size(), 32'd0);

        // Randomised traffic with random back-pressure; the source holds until accepted.
        begin
            bit acc;
            acc = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if (acc || !in_valid) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    op = $urandom_range(0, 1);
                    case ($urandom_range(0, 4))
                        0: a = 8'h80;
                        1: a = 8'hFF;
                        default: a = 8'($urandom_range(0, 255));
                    endcase
                    case ($urandom_range(0, 4))
                        0: b = 8'h7F;
                        1: b = 8'h00;
                        default: b = 8'($urandom_range(0, 255));
                    endcase
                end
                out_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("random_drained", exp_q.size(), 32'd0);

        // Reset with two operations in flight.
        send(1'b0, 8'd1, 8'd2);
        send(1'b0, 8'd3, 8'd4);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_result", {24'd0, result}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // WIDTH=16: carry/borrow across the half boundary in both directions.
        in_valid16 = 1'b1; op16 = 1'b1; a16 = 16'h0100; b16 = 16'h0001;
        @(posedge clk); #1;
        op16 = 1'b0; a16 = 16'h00FF; b16 = 16'h0001;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        @(negedge clk);
        check("w16_sub_valid", {31'd0, out_valid16}, 32'd1);
        check("w16_sub_res", {16'd0, result16}, 32'h00FF);
        check("w16_sub_flags", {28'd0, carry16, overflow16, zero16, negative16}, 32'd0);
        @(negedge clk);
        check("w16_add_valid", {31'd0, out_valid16}, 32'd1);
        check("w16_add_res", {16'd0, result16}, 32'h0100);
        check("w16_add_flags", {28'd0, carry16, overflow16, zero16, negative16}, 32'd0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
